// File: rtl/rr_fifo_arbiter_param.sv
// rr_fifo_arbiter_param: N independent write channels, each buffered in its own
// DEPTH-entry FIFO, merged round-robin onto one registered output word per cycle.
// MODE 0 rotates through slots whether or not they hold data; MODE 1 skips
// empty channels (work-conserving).
module rr_fifo_arbiter_param #(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   parameter int MODE  = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         wen,
   input  logic [N*WIDTH-1:0]   din,
   input  logic                 out_en,
   output logic [WIDTH-1:0]     dout,
   output logic [$clog2(N)-1:0] dout_ch,
   output logic                 valid,
   output logic [N-1:0]         full,
   output logic [N-1:0]         empty
);
   localparam int CW = $clog2(N);
   localparam int AW = $clog2(DEPTH);
   localparam int KW = AW + 1;

   logic [CW-1:0]           ptr;
   logic [CW-1:0]           grant;
   logic                    rd_en;
   logic [N-1:0]            do_rd;
   logic [N-1:0]            do_wr;
   logic [N-1:0][WIDTH-1:0] head;

   // Channel index ch+k modulo N (k < N), valid for any N, not only powers of 2.
   function automatic logic [CW-1:0] ch_add(input logic [CW-1:0] ch, input int k);
      int s;
      s = int'(ch) + k;
      if (s >= N) s = s - N;
      return CW'(s);
   endfunction

   // Grant selection from pre-edge occupancy and arbitration pointer only.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      rd_en = 1'b0;
      grant = ptr;
      if (out_en) begin
         if (MODE == 0) begin
            rd_en = !empty[ptr];
         end else begin
            // Walk from the farthest candidate back to ptr so the nearest non-empty wins.
            for (int k = N - 1; k >= 0; k--) begin
               if (!empty[ch_add(ptr, k)]) begin
                  rd_en = 1'b1;
                  grant = ch_add(ptr, k);
               end
            end
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_ch
      logic [WIDTH-1:0] mem [DEPTH];
      logic [AW-1:0]    rd_ptr;
      logic [AW-1:0]    wr_ptr;
      logic [KW-1:0]    count;

      // A full FIFO still accepts a write when it is being read at the same edge.
      assign do_rd[i] = rd_en && (grant == CW'(i));
      assign do_wr[i] = wen[i] && (!full[i] || do_rd[i]);
      assign full[i]  = (count == KW'(DEPTH));
      assign empty[i] = (count == '0);
      assign head[i]  = mem[rd_ptr];

      // Read/write pointers and occupancy count; pointers wrap naturally at DEPTH.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            // NOTE: non-blocking assignments, so every register here samples pre-edge values.
            if (do_wr[i]) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd[i]) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr[i], do_rd[i]})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end

      // Word storage.
      // NOTE: the array is deliberately not reset; emptiness lives in count, so stale words are never read.
      always_ff @(posedge clk) begin
         if (do_wr[i]) mem[wr_ptr] <= din[i*WIDTH +: WIDTH];
      end
   end

   // Registered output word, its source tag, and the arbitration pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout    <= '0;
         dout_ch <= '0;
         valid   <= 1'b0;
         ptr     <= '0;
      end else begin
         valid <= rd_en;
         if (rd_en) begin
            dout    <= head[grant];
            dout_ch <= grant;
         end else begin
            dout    <= '0;
         end
         if (MODE == 0) begin
            if (out_en) ptr <= ch_add(ptr, 1);
         end else if (rd_en) begin
            ptr <= ch_add(grant, 1);
         end
      end
   end

endmodule

// File: tb/tb_rr_fifo_arbiter_param.sv
// tb_rr_fifo_arbiter_param: one instance per arbitration mode, both fed the same
// directed stimulus. A queue-based model predicts every output each cycle, and
// hand-computed literals pin the scenario results.
module tb_rr_fifo_arbiter_param;
   localparam int N     = 4;
   localparam int WIDTH = 8;
   localparam int DEPTH = 8;

   typedef logic [WIDTH-1:0] word_t;

   logic             clk    = 1'b0;
   logic             rst_n  = 1'b0;
   logic [N-1:0]     wen    = '0;
   logic [N*WIDTH-1:0] din  = '0;
   logic             out_en = 1'b0;

   word_t        dout0, dout1;
   logic [1:0]   ch0, ch1;
   logic         valid0, valid1;
   logic [N-1:0] full0, full1, empty0, empty1;

   rr_fifo_arbiter_param #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(0)) u_m0 (
      .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .out_en(out_en),
      .dout(dout0), .dout_ch(ch0), .valid(valid0), .full(full0), .empty(empty0));

   rr_fifo_arbiter_param #(.N(N), .WIDTH(WIDTH), .DEPTH(DEPTH), .MODE(1)) u_m1 (
      .clk(clk), .rst_n(rst_n), .wen(wen), .din(din), .out_en(out_en),
      .dout(dout1), .dout_ch(ch1), .valid(valid1), .full(full1), .empty(empty1));

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   bit done  = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic word_t get_dout(input int m);
      return (m == 1) ? dout1 : dout0;
   endfunction
   function automatic logic [1:0] get_ch(input int m);
      return (m == 1) ? ch1 : ch0;
   endfunction
   function automatic logic get_valid(input int m);
      return (m == 1) ? valid1 : valid0;
   endfunction
   function automatic logic [N-1:0] get_full(input int m);
      return (m == 1) ? full1 : full0;
   endfunction
   function automatic logic [N-1:0] get_empty(input int m);
      return (m == 1) ? empty1 : empty0;
   endfunction

   // ---------------- behavioural model: one word queue per channel per mode
   word_t q [2*N][$];
   int    mptr [2]    = '{0, 0};
   word_t e_dout [2]  = '{8'd0, 8'd0};
   int    e_ch [2]    = '{0, 0};
   logic  e_valid [2] = '{1'b0, 1'b0};

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < N; i++) q[m*N+i].delete();
         mptr[m]    = 0;
         e_dout[m]  = '0;
         e_ch[m]    = 0;
         e_valid[m] = 1'b0;
      end
   endtask

   task automatic model_edge(input int m);
      int       base;
      int       g;
      bit       rd;
      bit [N-1:0] acc;
      base = m * N;
      g    = 0;
      rd   = 1'b0;
      if (out_en) begin
         if (m == 0) begin
            g  = mptr[0];
            rd = (q[base+g].size() > 0);
         end else begin
            for (int k = 0; k < N; k++) begin
               int c;
               c = (mptr[1] + k) % N;
               if (!rd && q[base+c].size() > 0) begin
                  rd = 1'b1;
                  g  = c;
               end
            end
         end
      end
      for (int i = 0; i < N; i++)
         acc[i] = wen[i] && (q[base+i].size() < DEPTH || (rd && g == i));
      if (rd) begin
         e_dout[m]  = q[base+g].pop_front();
         e_ch[m]    = g;
         e_valid[m] = 1'b1;
      end else begin
         e_dout[m]  = '0;
         e_valid[m] = 1'b0;
      end
      for (int i = 0; i < N; i++)
         if (acc[i]) q[base+i].push_back(din[i*WIDTH +: WIDTH]);
      if (m == 0) begin
         if (out_en) mptr[0] = (mptr[0] + 1) % N;
      end else if (rd) begin
         mptr[1] = (g + 1) % N;
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else for (int m = 0; m < 2; m++) model_edge(m);
   end

   // ---------------- compare process: every falling edge out of reset
   initial forever begin
      @(negedge clk);
      if (rst_n && !done) begin
         for (int m = 0; m < 2; m++) begin
            logic [N-1:0] ef, ee;
            for (int i = 0; i < N; i++) begin
               ef[i] = (q[m*N+i].size() == DEPTH);
               ee[i] = (q[m*N+i].size() == 0);
            end
            check($sformatf("m%0d valid", m), 64'(get_valid(m)), 64'(e_valid[m]));
            check($sformatf("m%0d dout", m),  64'(get_dout(m)),  64'(e_dout[m]));
            check($sformatf("m%0d dout_ch", m), 64'(get_ch(m)),  64'(e_ch[m]));
            check($sformatf("m%0d full", m),  64'(get_full(m)),  64'(ef));
            check($sformatf("m%0d empty", m), 64'(get_empty(m)), 64'(ee));
         end
      end
   end

   // ---------------- stimulus helpers
   task automatic step(input logic [N-1:0] w, input logic [N*WIDTH-1:0] d, input logic oe);
      wen    = w;
      din    = d;
      out_en = oe;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   // Literal expectation on one instance's output word.
   task automatic pin(input string name, input int m, input logic ev, input int ed, input int ec);
      check({name, " valid"}, 64'(get_valid(m)), 64'(ev));
      check({name, " dout"},  64'(get_dout(m)),  64'(ed));
      if (ev) check({name, " ch"}, 64'(get_ch(m)), 64'(ec));
   endtask

   function automatic logic [N*WIDTH-1:0] one(input int ch, input int v);
      logic [N*WIDTH-1:0] r;
      r = '0;
      r[ch*WIDTH +: WIDTH] = WIDTH'(v);
      return r;
   endfunction

   int rot_d [6] = '{9, 13, 87, 0, 0, 85};
   int rot_c [6] = '{2, 3, 0, 0, 0, 3};
   int rot_v [6] = '{1, 1, 1, 0, 0, 1};
   int drain_d [8] = '{11, 12, 13, 14, 15, 16, 17, 200};

   initial begin
      // Reset state
      #12;
      for (int m = 0; m < 2; m++) begin
         pin($sformatf("reset m%0d", m), m, 1'b0, 0, 0);
         check($sformatf("reset m%0d ch", m), 64'(get_ch(m)), 64'd0);
         check($sformatf("reset m%0d empty", m), 64'(get_empty(m)), 64'hF);
         check($sformatf("reset m%0d full", m), 64'(get_full(m)), 64'h0);
      end
      rst_n = 1'b1;

      // MODE 0 rotation (edge 1 advances ptr to 1 without a read)
      step(4'b1111, {8'd13, 8'd9, 8'd56, 8'd87}, 1'b1);
      step(4'b1000, one(3, 85), 1'b1);
      pin("rot e2", 0, 1'b1, 56, 1);
      for (int e = 0; e < 6; e++) begin
         step('0, '0, 1'b1);
         pin($sformatf("rot e%0d", e + 3), 0, rot_v[e][0], rot_d[e], rot_c[e]);
      end

      // MODE 1 work-conserving, single active channel
      @(posedge clk); #1; pulse_reset();
      step(4'b0001, one(0, 87), 1'b1);
      step(4'b0001, one(0, 89), 1'b1);
      pin("wc e2", 1, 1'b1, 87, 0);
      step(4'b0001, one(0, 91), 1'b1);
      pin("wc e3", 1, 1'b1, 89, 0);
      step('0, '0, 1'b1);
      pin("wc e4", 1, 1'b1, 91, 0);
      step('0, '0, 1'b1);
      pin("wc e5", 1, 1'b0, 0, 0);

      // Full / drop, then drain in MODE 1 (wraps both pointers)
      pulse_reset();
      for (int k = 1; k <= 9; k++) begin
         step(4'b0100, one(2, k), 1'b0);
         if (k >= 7) check($sformatf("drop full2 after w%0d", k), 64'(full1[2]), 64'(k >= 8));
      end
      for (int k = 1; k <= 9; k++) begin
         step('0, '0, 1'b1);
         if (k <= 8) pin($sformatf("drop out%0d", k), 1, 1'b1, k, 2);
         else        pin("drop out9", 1, 1'b0, 0, 0);
      end
      check("drop empty2", 64'(empty1[2]), 64'd1);

      // Full FIFO with concurrent read and write
      pulse_reset();
      for (int k = 0; k < 8; k++) step(4'b0010, one(1, 10 + k), 1'b0);
      check("rw full1 before", 64'(full1[1]), 64'd1);
      step(4'b0010, one(1, 200), 1'b1);
      pin("rw head", 1, 1'b1, 10, 1);
      check("rw full1 kept", 64'(full1[1]), 64'd1);
      for (int k = 0; k < 8; k++) begin
         step('0, '0, 1'b1);
         pin($sformatf("rw drain%0d", k), 1, 1'b1, drain_d[k], 1);
      end
      check("rw empty1", 64'(empty1[1]), 64'd1);

      // Backpressure with two loaded channels
      pulse_reset();
      step(4'b0101, one(0, 1) | one(2, 3), 1'b0);
      step(4'b0101, one(0, 2) | one(2, 4), 1'b0);
      step('0, '0, 1'b1);
      pin("bp e3", 1, 1'b1, 1, 0);
      step('0, '0, 1'b0);
      pin("bp e4", 1, 1'b0, 0, 0);
      step('0, '0, 1'b1);
      pin("bp e5", 1, 1'b1, 3, 2);
      step('0, '0, 1'b1);
      pin("bp e6", 1, 1'b1, 2, 0);
      step('0, '0, 1'b1);
      pin("bp e7", 1, 1'b1, 4, 2);
      for (int k = 0; k < 6; k++) step('0, '0, 1'b1);

      // Reset mid-run: outputs clear without a clock, no stale word afterwards
      pulse_reset();
      for (int k = 0; k < 3; k++) step(4'b0001, one(0, 5 + k), 1'b0);
      step('0, '0, 1'b1);
      pin("pre-reset", 1, 1'b1, 5, 0);
      rst_n = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) begin
         pin($sformatf("async m%0d", m), m, 1'b0, 0, 0);
         check($sformatf("async m%0d ch", m), 64'(get_ch(m)), 64'd0);
         check($sformatf("async m%0d empty", m), 64'(get_empty(m)), 64'hF);
         check($sformatf("async m%0d full", m), 64'(get_full(m)), 64'h0);
      end
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step('0, '0, 1'b1);
         pin($sformatf("post-reset %0d", k), 1, 1'b0, 0, 0);
      end

      @(negedge clk);
      done = 1'b1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
